// File: rtl/alu_wide_seq.sv
// Multi-word arithmetic sequencer: feeds a 32-bit ALU one word per cycle.
// Define ALU_SEQ_CMP_EN to enable op 100 (CMP: SUB flags, result dropped).
module alu_wide_seq #(
  parameter int NWORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [32*NWORDS-1:0]  req_a,
  input  logic [32*NWORDS-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*NWORDS-1:0]  rsp_res,
  output logic [3:0]            rsp_sr,
  output logic [31:0]           alu_val1,
  output logic [31:0]           alu_val2,
  output logic                  alu_carry,
  output logic [3:0]            alu_cmd,
  input  logic [31:0]           alu_res,
  input  logic [3:0]            alu_sr
);

  localparam int W  = 32 * NWORDS;
  localparam int IW = $clog2(NWORDS);

`ifdef ALU_SEQ_CMP_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_EOR = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_EOR = 4'b1000;

  // FIN forms the aggregate flags from the fully assembled result
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic            v_q, v_d;
  logic [W-1:0]    res_q, res_d;
  logic [3:0]      sr_q, sr_d;

  logic            is_add, is_sub, is_and, is_eor, is_cmp, arith;
  logic            first, last;
  logic [31:0]     a_w, b_w;
  logic            cy_next;
  logic            unused_sr;

  assign unused_sr = ^{alu_sr[3], alu_sr[1]};

  always_comb begin
    is_cmp = CmpEn && (op_q == OP_CMP);
    is_add = (op_q == OP_ADD);
    is_sub = (op_q == OP_SUB) || is_cmp;
    is_and = (op_q == OP_AND);
    is_eor = (op_q == OP_EOR);
    arith  = is_add || is_sub;
  end

  assign first = (idx_q == '0);
  assign last  = (idx_q == IW'(NWORDS - 1));

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IW'(i)) begin
        a_w = a_q[32*i +: 32];
        b_w = b_q[32*i +: 32];
      end
    end
  end

  // Borrow chain is resolved here rather than trusting the ALU's SUB carry
  always_comb begin
    cy_next = 1'b0;
    unique case (1'b1)
      is_add: cy_next = alu_sr[2];
      is_sub: cy_next = (a_w > b_w) ||
                        ((a_w == b_w) && (first || cy_q));
      default: cy_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      v_q     <= v_d;
      res_q   <= res_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_FIN;
      S_FIN:   state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    cy_d  = cy_q;
    v_d   = v_q;
    res_d = res_q;
    sr_d  = sr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          idx_d = '0;
          cy_d  = 1'b0;
          v_d   = 1'b0;
        end
      end
      S_RUN: begin
        cy_d  = cy_next;
        idx_d = last ? '0 : idx_q + IW'(1);
        for (int i = 0; i < NWORDS; i++) begin
          if (idx_q == IW'(i)) res_d[32*i +: 32] = alu_res;
        end
        if (last) v_d = alu_sr[0];
      end
      S_FIN: begin
        sr_d = {~|res_q, arith & cy_q, res_q[W-1], arith & v_q};
        if (is_cmp) res_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    rsp_res   = res_q;
    rsp_sr    = sr_q;
    alu_val1  = '0;
    alu_val2  = '0;
    alu_carry = 1'b0;
    alu_cmd   = EX_NOP;
    if (state_q == S_RUN) begin
      alu_val1  = a_w;
      alu_val2  = b_w;
      alu_carry = cy_q;
      unique case (1'b1)
        is_add:  alu_cmd = first ? EX_ADD : EX_ADC;
        is_sub:  alu_cmd = first ? EX_SUB : EX_SBC;
        is_and:  alu_cmd = EX_AND;
        is_eor:  alu_cmd = EX_EOR;
        default: alu_cmd = EX_NOP;
      endcase
    end
  end

endmodule
